inst_sequencer: RTL
===================

// Module: inst_sequencer
// PURPOSE
//  Multi-cycle fetch/execute sequencer for the X9 core; owns the program counter (PC) and the condition flag.
//  - Steps each instruction through FETCH/DECODE/EXEC/MEM/WB.
//  - Consumes the 5-bit opcode that also feeds the control decoder.
//  - Gates IR load, register-file write and data-memory requests (req/ack handshake).
//  - Resolves beq/bne against the flag set by eq/lt.
// PARAMETERS
//  PCW   10  PC / instruction-address width
//  CNTW  16  width of performance counters (PERF_CNT_EN only)
// PORTS
//  clk            in   1     single clock, rising edge
//  reset          in   1     asynchronous, active-high
//  start          in   1     begin run at PC=0; sampled in IDLE/DONE only
//  prog_end       in   PCW   address of last program instruction
//  opcode         in   5     IR[8:4], stable from DECODE until instruction retires
//  branch_target  in   PCW   taken-branch destination, valid in EXEC
//  alu_cond       in   1     ALU compare result for eq/lt, valid in EXEC
//  mem_ack        in   1     data memory completion, 1-cycle pulse
//  pc             out  PCW   current instruction address
//  ir_load        out  1     IR capture strobe
//  reg_we         out  1     register-file write enable
//  mem_req        out  1     data memory request
//  mem_we         out  1     1=store (sb), 0=load (lb); qualified by mem_req
//  cond_flag      out  1     flag written by eq/lt
//  busy           out  1     1 in any state except IDLE/DONE
//  done           out  1     program finished
//  instr_count    out  CNTW  retired instructions (PERF_CNT_EN)
//  cycle_count    out  CNTW  cycles spent busy (PERF_CNT_EN)
// BEHAVIOUR
//  Reset: state=IDLE; pc=0; cond_flag=0; counters=0; all strobes/done/busy=0. Async, so mem_req drops immediately mid-access.
//  Outputs are Moore-decoded from the registered state; pc and cond_flag are registers.
//  States and transitions:
//    IDLE:   start -> FETCH.
//    FETCH:  ir_load=1 for 1 cycle -> DECODE.
//    DECODE: 1 cycle -> EXEC.
//    EXEC:   dispatch on opcode:
//      lb 00011 / sb 00100 -> MEM.
//      beq 00101: taken when cond_flag=1. bne 00110: taken when cond_flag=0.
//        Taken: pc<=branch_target, go FETCH. Not taken: RETIRE path.
//      eq 01101 / lt 01110: cond_flag<=alu_cond, then RETIRE.
//      All other opcodes (incl. movr 10???, movi 11???) -> WB.
//    MEM:    mem_req=1 held every cycle until the cycle mem_ack=1.
//      mem_we=1 for sb. On ack: lb -> WB, sb -> RETIRE.
//      mem_ack outside MEM is ignored.
//    WB:     reg_we=1 for exactly 1 cycle, then RETIRE.
//    RETIRE (performed on exit edge, not a state):
//      pc==prog_end -> DONE, pc unchanged.
//      Otherwise pc<=pc+1 modulo 2^PCW (wraps 2^PCW-1 -> 0), go FETCH.
//    DONE:   done=1 held. start -> pc<=0, cond_flag<=0, go FETCH.
//  Taken branch never checks prog_end; a branch at prog_end to an earlier address loops.
//  Latency (cycles from FETCH to next FETCH):
//    ALU ops / movr / movi: 4. eq/lt: 3. Branch (taken or not): 3.
//    lb: 5 + wait cycles. sb: 4 + wait cycles.
//  start while busy is ignored. start and mem_ack are never both relevant in one state.
// CONFIGURATION
//  PERF_CNT_EN defined:
//    cycle_count increments every busy cycle.
//    instr_count increments at each retire and each taken branch.
//    Both saturate at 2^CNTW-1 and clear on reset and on start from IDLE/DONE.
//  PERF_CNT_EN undefined: counter logic removed, both outputs tied to 0.
// TESTING
//  1. Reset, prog_end=0, opcode=00000 (add), pulse start
//     -> ir_load@cycle1, reg_we@cycle4 only, done=1@cycle5, pc stays 0.
//  2. lb with mem_ack delayed 3 cycles
//     -> mem_req high exactly 4 cycles with mem_we=0, then reg_we 1 cycle, pc+1.
//  3. sb with immediate ack -> mem_req=mem_we=1 for 1 cycle, reg_we never asserted.
//  4. eq with alu_cond=1, then beq with branch_target=0x005 -> cond_flag=1, pc=0x005.
//     Repeat with bne -> not taken, pc+1.
//  5. pc=2^PCW-1 (prog_end=0) retiring an ALU op -> pc wraps to 0, no done.
//  6. Assert reset during MEM with mem_req=1 -> mem_req/busy 0 same cycle, pc=0, state IDLE.
//     Under PERF_CNT_EN, counters read 0.

Source files
------------

// File: rtl/inst_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the X9 core; owns pc and cond_flag.
// Optional PERF_CNT_EN adds saturating retired-instruction and busy-cycle counters.
module inst_sequencer #(
    parameter int unsigned PCW  = 10,
    parameter int unsigned CNTW = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [PCW-1:0]  prog_end,
    input  logic [4:0]      opcode,
    input  logic [PCW-1:0]  branch_target,
    input  logic            alu_cond,
    input  logic            mem_ack,
    output logic [PCW-1:0]  pc,
    output logic            ir_load,
    output logic            reg_we,
    output logic            mem_req,
    output logic            mem_we,
    output logic            cond_flag,
    output logic            busy,
    output logic            done,
    output logic [CNTW-1:0] instr_count,
    output logic [CNTW-1:0] cycle_count
);

    localparam logic [4:0] OP_LB  = 5'b00011;
    localparam logic [4:0] OP_SB  = 5'b00100;
    localparam logic [4:0] OP_BEQ = 5'b00101;
    localparam logic [4:0] OP_BNE = 5'b00110;
    localparam logic [4:0] OP_EQ  = 5'b01101;
    localparam logic [4:0] OP_LT  = 5'b01110;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_DONE
    } state_t;

    state_t         state;
    state_t         nxt;
    logic [PCW-1:0] pc_nxt;
    logic           flag_nxt;
    logic           retire;
    logic           taken;

    // Next-state, pc and flag; retire is folded into the exit edge of EXEC/MEM/WB.
    always_comb begin
        nxt      = state;
        pc_nxt   = pc;
        flag_nxt = cond_flag;
        retire   = 1'b0;
        taken    = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    nxt      = S_FETCH;
                    pc_nxt   = '0;
                    flag_nxt = 1'b0;
                end
            end
            S_FETCH:  nxt = S_DECODE;
            S_DECODE: nxt = S_EXEC;
            S_EXEC: begin
                case (opcode)
                    OP_LB, OP_SB: nxt = S_MEM;
                    OP_BEQ: begin
                        if (cond_flag) taken  = 1'b1;
                        else           retire = 1'b1;
                    end
                    OP_BNE: begin
                        if (!cond_flag) taken  = 1'b1;
                        else            retire = 1'b1;
                    end
                    OP_EQ, OP_LT: begin
                        flag_nxt = alu_cond;
                        retire   = 1'b1;
                    end
                    default: nxt = S_WB;
                endcase
            end
            S_MEM: begin
                if (mem_ack) begin
                    if (opcode == OP_SB) retire = 1'b1;
                    else                 nxt    = S_WB;
                end
            end
            S_WB:    retire = 1'b1;
            default: nxt = S_IDLE;
        endcase

        if (taken) begin
            pc_nxt = branch_target;
            nxt    = S_FETCH;
        end
        if (retire) begin
            if (pc == prog_end) begin
                nxt = S_DONE;
            end else begin
                pc_nxt = pc + PCW'(1);
                nxt    = S_FETCH;
            end
        end
    end

    // Strobes are registered from the next state so they align with the state they decode.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            pc        <= '0;
            cond_flag <= 1'b0;
            ir_load   <= 1'b0;
            reg_we    <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= nxt;
            pc        <= pc_nxt;
            cond_flag <= flag_nxt;
            ir_load   <= (nxt == S_FETCH);
            reg_we    <= (nxt == S_WB);
            mem_req   <= (nxt == S_MEM);
            mem_we    <= (nxt == S_MEM) && (opcode == OP_SB);
            busy      <= !((nxt == S_IDLE) || (nxt == S_DONE));
            done      <= (nxt == S_DONE);
        end
    end

`ifdef PERF_CNT_EN
    localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};

    logic in_busy;
    logic run_start;

    assign in_busy   = !((state == S_IDLE) || (state == S_DONE));
    assign run_start = start && !in_busy;

    // Saturating counters, cleared whenever a new run is launched.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_count <= '0;
            cycle_count <= '0;
        end else if (run_start) begin
            instr_count <= '0;
            cycle_count <= '0;
        end else begin
            if (in_busy && (cycle_count != CNT_MAX))
                cycle_count <= cycle_count + CNTW'(1);
            if ((retire || taken) && (instr_count != CNT_MAX))
                instr_count <= instr_count + CNTW'(1);
        end
    end
`else
    assign instr_count = '0;
    assign cycle_count = '0;
`endif

endmodule
